// File: rtl/cos_tone_detector.sv
// cos_tone_detector: correlates a signed 8-bit sample stream against an
// external registered cosine ROM over a fixed window. It reports the
// signed correlation and a magnitude-vs-threshold detect flag.
// Optional build macro: COS_DET_PHASE_CLR_EN. When it is defined, the
// phase is re-zeroed on the last sample of each window.
//
// state | meaning
// IDLE  | not accepting samples; pipeline, acc, count and phase are clear
// RUN   | accepting samples; an enable drop aborts the window, no result
module cos_tone_detector #(
  parameter int PHASE_W    = 16,
  parameter int WINDOW_LEN = 256,
  parameter int ACC_W      = 16 + $clog2(WINDOW_LEN)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [PHASE_W-1:0]       phase_inc,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [7:0]        sample_in,
  output logic [7:0]               lut_address,
  input  logic signed [7:0]        lut_q,
  input  logic [ACC_W-1:0]         threshold,
  output logic                     result_valid,
  output logic signed [ACC_W-1:0]  result_corr,
  output logic                     detect
);

  localparam int CNT_W = $clog2(WINDOW_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state_q, state_d;
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic signed [7:0]        s1_q, s1_d;
  logic                     v1_q, v1_d;
  logic signed [15:0]       p2_q, p2_d;
  logic                     v2_q, v2_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     rv_q, rv_d;
  logic signed [ACC_W-1:0]  corr_q, corr_d;
  logic                     det_q, det_d;

  logic                     accept;
  logic signed [15:0]       prod;
  logic signed [ACC_W-1:0]  sum;
  logic [ACC_W:0]           sum_ext;
  logic [ACC_W:0]           sum_abs;

  assign in_ready     = (state_q == RUN);
  assign accept       = in_valid & in_ready;
  assign lut_address  = phase_q[PHASE_W-1 -: 8];
  assign result_valid = rv_q;
  assign result_corr  = corr_q;
  assign detect       = det_q;

  // Pipeline arithmetic; the magnitude is taken one bit wider so that the
  // most negative sum maps to 2^(ACC_W-1) without wrapping.
  assign prod    = s1_q * lut_q;
  assign sum     = acc_q + {{(ACC_W-16){p2_q[15]}}, p2_q};
  assign sum_ext = {sum[ACC_W-1], sum};
  assign sum_abs = sum_ext[ACC_W] ? (~sum_ext + 1'b1) : sum_ext;

`ifdef COS_DET_PHASE_CLR_EN
  // Window index of the sample being accepted now. Samples still in flight
  // in s1/p2 are counted ahead of the accumulated count; the index wraps
  // naturally because the window length is a power of two.
  logic [CNT_W-1:0] accept_idx;
  assign accept_idx = count_q + CNT_W'(v1_q) + CNT_W'(v2_q);
`endif

  // Next-state logic for the FSM and the sample/accumulate pipeline.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    s1_d    = s1_q;
    v1_d    = 1'b0;
    p2_d    = prod;
    v2_d    = v1_q;
    acc_d   = acc_q;
    count_d = count_q;
    rv_d    = 1'b0;
    corr_d  = corr_q;
    det_d   = det_q;

    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          v2_d    = 1'b0;
          acc_d   = '0;
          count_d = '0;
          phase_d = '0;
        end else begin
          if (accept) begin
            s1_d    = sample_in;
            v1_d    = 1'b1;
            phase_d = phase_q + phase_inc;
`ifdef COS_DET_PHASE_CLR_EN
            if (accept_idx == LAST_IDX) phase_d = '0;
`endif
          end
          if (v2_q) begin
            if (count_q == LAST_IDX) begin
              corr_d  = sum;
              det_d   = (sum_abs >= {1'b0, threshold});
              rv_d    = 1'b1;
              acc_d   = '0;
              count_d = '0;
            end else begin
              acc_d   = sum;
              count_d = count_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      s1_q    <= '0;
      v1_q    <= 1'b0;
      p2_q    <= '0;
      v2_q    <= 1'b0;
      acc_q   <= '0;
      count_q <= '0;
      rv_q    <= 1'b0;
      corr_q  <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      s1_q    <= s1_d;
      v1_q    <= v1_d;
      p2_q    <= p2_d;
      v2_q    <= v2_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      rv_q    <= rv_d;
      corr_q  <= corr_d;
      det_q   <= det_d;
    end
  end

endmodule
